wb_slave_mem: RTL and testbench
===============================

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, memory depth in DATA_W words.
REQ-003 Parameter WAIT_ST, default 1, wait cycles between request sample and ack; range 0..15.
REQ-004 Parameter MBOX_VALID, default 320, word index of the test-valid flag.
REQ-005 Parameter MBOX_DATA, default 321, word index of the test result.
REQ-006 Parameter TIMEOUT, default 600, watchdog limit in clock cycles.
REQ-007 i_clk  in  1  clock; all logic on rising edge.
REQ-008 i_arst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_wb_cyc / i_wb_stb  in  1 each  Wishbone cycle / strobe.
REQ-010 i_wb_we  in  1  write enable.
REQ-011 i_wb_sel  in  DATA_W/8  byte lane selects.
REQ-012 i_wb_adr  in  32  byte address; word index = adr >> log2(DATA_W/8).
REQ-013 i_wb_dat  in  DATA_W  write data.
REQ-014 o_wb_dat  out  DATA_W  read data, valid while o_wb_ack high.
REQ-015 o_wb_ack / o_wb_err  out  1 each  normal / error termination.
REQ-016 i_test_clr  in  1  clears mailbox flags, restarts watchdog.
REQ-017 o_test_done  out  1  sticky: test reported completion.
REQ-018 o_test_result  out  DATA_W  result word captured at completion.
REQ-019 o_timeout  out  1  sticky: watchdog expired before completion.

Function
REQ-020 FSM states IDLE, WAIT, TERM; IDLE -> WAIT when cyc&stb high (skip to TERM if WAIT_ST=0); WAIT -> TERM after WAIT_ST cycles; TERM -> IDLE unconditionally.
REQ-021 Request latency: ack/err asserted exactly WAIT_ST+1 cycles after the edge that samples cyc&stb, for exactly one cycle.
REQ-022 Back-to-back requests: IDLE re-samples on the cycle after TERM; minimum spacing WAIT_ST+2 cycles.
REQ-023 cyc or stb deasserted while in WAIT: abort to IDLE, no ack, no err, no memory write.
REQ-024 Address, we, sel and write data latched at sample; later bus changes ignored for that transfer.
REQ-025 Word index >= DEPTH: o_wb_err instead of o_wb_ack, no write, o_wb_dat = 0.
REQ-026 Write commits at TERM edge; only lanes with sel bit high updated.
REQ-027 Read returns full word at latched index regardless of sel; o_wb_dat = 0 outside TERM.
REQ-028 Memory array exposed as hierarchical array named mem for $readmemh preload and backdoor access.
REQ-029 Committed write to MBOX_VALID with data == 1 sets o_test_done; o_test_result <= mem[MBOX_DATA] as of that edge.
REQ-030 Write to MBOX_VALID with any other value: memory updated, flags unchanged.
REQ-031 Watchdog: counter increments each cycle while o_test_done=0 and o_timeout=0; reaching TIMEOUT sets o_timeout and stops counting; counter width ceil(log2(TIMEOUT+1)), no wrap.
REQ-032 o_test_done and o_timeout mutually exclusive: whichever sets first blocks the other until cleared.
REQ-033 i_test_clr high: next edge clears o_test_done, o_timeout, o_test_result, counter, and word MBOX_VALID; a simultaneous MBOX_VALID write still commits other words, but the clear wins for flags and MBOX_VALID.
REQ-034 Bus FSM unaffected by i_test_clr.

Reset
REQ-035 Reset low: FSM IDLE, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_test_done=0, o_timeout=0, o_test_result=0, counter=0, immediately (asynchronous).
REQ-036 Memory contents SHALL NOT be reset; preload survives reset.
REQ-037 Reset mid-transfer: transfer dropped, no write, no ack after release.
REQ-038 Release synchronous to i_clk; first request sampled on the first rising edge with i_arst_n high.

Verification
REQ-039 WAIT_ST=1: write 0x12345678 to word 5, sel=4'b0011 over preload 0xAAAAAAAA -> ack 2 cycles after sample, read of word 5 returns 0xAAAA5678.
REQ-040 WAIT_ST=0 and WAIT_ST=3: single reads -> ack at cycle 1 / cycle 4, one cycle wide; stb dropped in WAIT -> no ack, word unchanged.
REQ-041 Access to word DEPTH -> o_wb_err one cycle, o_wb_ack stays 0, memory unchanged.
REQ-042 Write 21 to word 321 then 1 to word 320 -> o_test_done=1, o_test_result=21, watchdog frozen, o_timeout stays 0.
REQ-043 No mailbox write for 600 cycles -> o_timeout=1 at cycle 600; i_test_clr -> flags 0, counter restarts.
REQ-044 Assert i_arst_n=0 during WAIT of a write -> outputs 0 same cycle, target word unchanged, preloaded words intact.

Source files
------------

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between a master and the wb_slave_mem test memory.
// Byte addressing on adr; sel carries one bit per byte lane of the data bus.
interface wb_slave_mem_if #(
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DATA_W/8-1:0]   sel;
    logic [31:0]           adr;
    logic [DATA_W-1:0]     dat_w;
    logic [DATA_W-1:0]     dat_r;
    logic                  ack;
    logic                  err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone slave memory with fixed wait states, plus a test mailbox and watchdog
// that report completion or timeout of software running against this memory.
module wb_slave_mem #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int WAIT_ST    = 1,
    parameter int MBOX_VALID = 320,
    parameter int MBOX_DATA  = 321,
    parameter int TIMEOUT    = 600
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    wb_slave_mem_if.slave     wb,
    input  logic              i_test_clr,
    output logic              o_test_done,
    output logic [DATA_W-1:0] o_test_result,
    output logic              o_timeout
);
    localparam int NB  = DATA_W / 8;
    localparam int BSH = (NB > 1) ? $clog2(NB) : 0;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] L_MBV = AW'(MBOX_VALID);
    localparam logic [AW-1:0] L_MBD = AW'(MBOX_DATA);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

    state_t              r_state, w_state_nx;
    logic [3:0]          r_wcnt, w_wcnt_nx;
    logic                r_we;
    logic [NB-1:0]       r_sel;
    logic [31:0]         r_widx;
    logic [DATA_W-1:0]   r_wdat;
    logic                r_ack, r_err;
    logic [DATA_W-1:0]   r_rdat;
    logic                r_done, r_timeout;
    logic [DATA_W-1:0]   r_result;
    logic [CW-1:0]       r_wdog;

    logic                w_req, w_sample, w_oor, w_term, w_commit, w_mbox_set, w_armed;
    logic [AW-1:0]       w_idx;
    logic [DATA_W-1:0]   w_rword, w_merged;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign w_req = wb.cyc & wb.stb;

    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        w_sample   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_sample   = 1'b1;
                    w_wcnt_nx  = 4'd0;
                    w_state_nx = (WAIT_ST == 0) ? S_TERM : S_WAIT;
                end
            end
            S_WAIT: begin
                // Losing cyc or stb mid-wait drops the transfer silently.
                if (!w_req)
                    w_state_nx = S_IDLE;
                else if (r_wcnt == 4'(WAIT_ST - 1))
                    w_state_nx = S_TERM;
                else
                    w_wcnt_nx = r_wcnt + 4'd1;
            end
            S_TERM:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_widx  <= '0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_wcnt  <= w_wcnt_nx;
            if (w_sample) begin
                r_we   <= wb.we;
                r_sel  <= wb.sel;
                r_widx <= wb.adr >> BSH;
                r_wdat <= wb.dat_w;
            end
        end
    end

    assign w_term   = (r_state == S_TERM);
    assign w_oor    = (r_widx >= 32'(DEPTH));
    assign w_idx    = r_widx[AW-1:0];
    assign w_rword  = mem[w_idx];
    assign w_commit = w_term && r_we && !w_oor;

    always_comb begin
        w_merged = w_rword;
        for (int b = 0; b < NB; b++)
            if (r_sel[b]) w_merged[b*8 +: 8] = r_wdat[b*8 +: 8];
    end

    // Ack/err/data are registered off the TERM state, so the response lands
    // WAIT_ST+1 edges after the sampling edge and lasts one cycle.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_rdat <= '0;
        end else begin
            r_ack  <= w_term && !w_oor;
            r_err  <= w_term && w_oor;
            r_rdat <= (w_term && !w_oor && !r_we) ? w_rword : '0;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.err   = r_err;
    assign wb.dat_r = r_rdat;

    // No reset on the array so preloaded images survive i_arst_n.
    always_ff @(posedge i_clk) begin
        if (w_commit)
            mem[w_idx] <= w_merged;
        if (i_test_clr && (MBOX_VALID < DEPTH))
            mem[L_MBV] <= '0;
    end

    assign w_mbox_set = w_commit && (r_widx == 32'(MBOX_VALID)) && (w_merged == DATA_W'(1));
    assign w_armed    = !r_done && !r_timeout;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
            r_wdog    <= '0;
        end else if (i_test_clr) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
            r_wdog    <= '0;
        end else if (w_armed) begin
            if (w_mbox_set) begin
                r_done   <= 1'b1;
                r_result <= (MBOX_DATA < DEPTH) ? mem[L_MBD] : '0;
            end else begin
                r_wdog <= r_wdog + CW'(1);
                if (r_wdog == CW'(TIMEOUT - 1))
                    r_timeout <= 1'b1;
            end
        end
    end

    assign o_test_done   = r_done;
    assign o_timeout     = r_timeout;
    assign o_test_result = r_result;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: three instances (WAIT_ST 0/1/3) sharing the bus
// fields, each with its own strobe so only one slave responds at a time.
module tb_wb_slave_mem;
    logic        clk, rst_n, clr, cyc, we;
    logic [2:0]  stbv;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        done0, done1, done3, to0, to1, to3;
    logic [31:0] res0, res1, res3;
    int          n_cmp, n_bad;

    wb_slave_mem_if #(.DATA_W(32)) bus0 ();
    wb_slave_mem_if #(.DATA_W(32)) bus1 ();
    wb_slave_mem_if #(.DATA_W(32)) bus3 ();

    assign bus0.cyc = cyc;  assign bus0.stb = stbv[0]; assign bus0.we = we;
    assign bus0.sel = sel;  assign bus0.adr = adr;     assign bus0.dat_w = wdat;
    assign bus1.cyc = cyc;  assign bus1.stb = stbv[1]; assign bus1.we = we;
    assign bus1.sel = sel;  assign bus1.adr = adr;     assign bus1.dat_w = wdat;
    assign bus3.cyc = cyc;  assign bus3.stb = stbv[2]; assign bus3.we = we;
    assign bus3.sel = sel;  assign bus3.adr = adr;     assign bus3.dat_w = wdat;

    wb_slave_mem #(.WAIT_ST(0)) dut0 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus0), .i_test_clr(clr),
        .o_test_done(done0), .o_test_result(res0), .o_timeout(to0));
    wb_slave_mem dut1 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus1), .i_test_clr(clr),
        .o_test_done(done1), .o_test_result(res1), .o_timeout(to1));
    wb_slave_mem #(.WAIT_ST(3)) dut3 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus3), .i_test_clr(clr),
        .o_test_done(done3), .o_test_result(res3), .o_timeout(to3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ackof(input int d);
        case (d)
            0:       return bus0.ack;
            1:       return bus1.ack;
            default: return bus3.ack;
        endcase
    endfunction

    function automatic logic errof(input int d);
        case (d)
            0:       return bus0.err;
            1:       return bus1.err;
            default: return bus3.err;
        endcase
    endfunction

    function automatic logic [31:0] datof(input int d);
        case (d)
            0:       return bus0.dat_r;
            1:       return bus1.dat_r;
            default: return bus3.dat_r;
        endcase
    endfunction

    // One transfer to slave d; strobe held for 'hold' edges after the sample edge,
    // then the bus is dropped and scrambled. lat = edges after sample to first ack/err.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] dt, input int hold,
                        output int lat, output int nack, output int nerr, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stbv = 3'b000; stbv[d] = 1'b1; we = w; adr = a; sel = s; wdat = dt;
        lat = -1; nack = 0; nerr = 0; rd = 32'hDEAD_DEAD;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ackof(d) || errof(d)) begin
                if (lat < 0) lat = k;
                rd = datof(d);
            end
            if (ackof(d)) nack++;
            if (errof(d)) nerr++;
            if (k == hold) begin
                cyc = 1'b0; stbv = 3'b000; we = ~w; adr = 32'hFFFF_FFFC; sel = 4'h0; wdat = ~dt;
            end
            @(posedge clk);
        end
    endtask

    int lat, nack, nerr;
    logic [31:0] rd;

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; cyc = 1'b0; stbv = 3'b000; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus1.ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus1.ack); end
        n_cmp++; if (bus1.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus1.err); end
        n_cmp++; if (bus1.dat_r !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", bus1.dat_r); end
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done1); end
        n_cmp++; if (to1 !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", to1); end
        n_cmp++; if (res1 !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", res1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_byte_lanes();
        xfer(1, 1'b1, 32'h14, 4'hF, 32'hAAAA_AAAA, 1, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 2 || nack !== 1) begin n_bad++; $display("FAIL preload_ack: lat %0d acks %0d want 2/1", lat, nack); end
        xfer(1, 1'b1, 32'h14, 4'b0011, 32'h1234_5678, 1, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 2 || nack !== 1 || nerr !== 0) begin n_bad++; $display("FAIL lane_wr_ack: lat %0d acks %0d errs %0d want 2/1/0", lat, nack, nerr); end
        xfer(1, 1'b0, 32'h14, 4'b0000, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 2 || nack !== 1) begin n_bad++; $display("FAIL lane_rd_ack: lat %0d acks %0d want 2/1", lat, nack); end
        n_cmp++; if (rd !== 32'hAAAA_5678) begin n_bad++; $display("FAIL lane_rd_data: got %h want aaaa5678", rd); end
    endtask

    task automatic test_error();
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 1, lat, nack, nerr, rd);
        xfer(1, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1, lat, nack, nerr, rd);
        n_cmp++; if (nerr !== 1 || nack !== 0 || lat !== 2) begin n_bad++; $display("FAIL oor_err: errs %0d acks %0d lat %0d want 1/0/2", nerr, nack, lat); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_dat: got %h want 0", rd); end
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL oor_nowrite: got %h want 0badf00d", rd); end
    endtask

    task automatic test_abort();
        xfer(1, 1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 0, lat, nack, nerr, rd);
        n_cmp++; if (nack !== 0 || nerr !== 0) begin n_bad++; $display("FAIL abort_resp: acks %0d errs %0d want 0/0", nack, nerr); end
        xfer(1, 1'b0, 32'h14, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'hAAAA_5678) begin n_bad++; $display("FAIL abort_nowrite: got %h want aaaa5678", rd); end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  mask;
        logic [31:0] d2, d5;
        mask = '0; d2 = '0; d5 = '0;
        @(negedge clk);
        cyc = 1'b1; stbv = 3'b010; we = 1'b0; adr = 32'h14; sel = 4'hF;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.ack) mask[k] = 1'b1;
            if (k == 2) d2 = bus1.dat_r;
            if (k == 5) d5 = bus1.dat_r;
            if (k == 1) adr = 32'h0;
            if (k == 5) begin cyc = 1'b0; stbv = 3'b000; end
        end
        n_cmp++; if (mask !== 9'b000100100) begin n_bad++; $display("FAIL b2b_ack_pattern: got %b want 000100100", mask); end
        n_cmp++; if (d2 !== 32'hAAAA_5678) begin n_bad++; $display("FAIL b2b_first_data: got %h want aaaa5678", d2); end
        n_cmp++; if (d5 !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_second_data: got %h want 0badf00d", d5); end
    endtask

    task automatic test_mailbox();
        xfer(1, 1'b1, 32'h500, 4'hF, 32'd2, 1, lat, nack, nerr, rd);
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL mbox_non1: done %b want 0", done1); end
        xfer(1, 1'b1, 32'h504, 4'hF, 32'd21, 1, lat, nack, nerr, rd);
        xfer(1, 1'b1, 32'h500, 4'hF, 32'd1, 1, lat, nack, nerr, rd);
        n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL mbox_done: got %b want 1", done1); end
        n_cmp++; if (res1 !== 32'd21) begin n_bad++; $display("FAIL mbox_result: got %0d want 21", res1); end
        repeat (700) @(posedge clk);
        #1;
        n_cmp++; if (to1 !== 1'b0 || done1 !== 1'b1) begin n_bad++; $display("FAIL mbox_frozen: timeout %b done %b want 0/1", to1, done1); end
    endtask

    task automatic test_clear_timeout();
        int n;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        n_cmp++; if (done1 !== 1'b0 || res1 !== 32'h0 || to1 !== 1'b0) begin n_bad++; $display("FAIL clr_flags: done %b result %h timeout %b want 0/0/0", done1, res1, to1); end
        n = 0;
        while (to1 !== 1'b1 && n < 700) begin
            @(posedge clk); n++; #1;
        end
        n_cmp++; if (n !== 600) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 600", n); end
        xfer(1, 1'b0, 32'h500, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clr_mbox_word: got %h want 0", rd); end
        xfer(1, 1'b1, 32'h500, 4'hF, 32'd1, 1, lat, nack, nerr, rd);
        n_cmp++; if (done1 !== 1'b0 || to1 !== 1'b1) begin n_bad++; $display("FAIL exclusive: done %b timeout %b want 0/1", done1, to1); end
        xfer(1, 1'b0, 32'h500, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL exclusive_mem: got %h want 1", rd); end
    endtask

    task automatic test_wait0();
        xfer(0, 1'b1, 32'h1C, 4'hF, 32'hCAFE_BABE, 0, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 1 || nack !== 1) begin n_bad++; $display("FAIL ws0_wr: lat %0d acks %0d want 1/1", lat, nack); end
        xfer(0, 1'b0, 32'h1C, 4'hF, 32'h0, 0, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 1 || nack !== 1 || rd !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL ws0_rd: lat %0d acks %0d data %h want 1/1/cafebabe", lat, nack, rd); end
    endtask

    task automatic test_wait3();
        xfer(2, 1'b1, 32'h1C, 4'hF, 32'h1122_3344, 3, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 4 || nack !== 1) begin n_bad++; $display("FAIL ws3_wr: lat %0d acks %0d want 4/1", lat, nack); end
        xfer(2, 1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF, 1, lat, nack, nerr, rd);
        n_cmp++; if (nack !== 0 || nerr !== 0) begin n_bad++; $display("FAIL ws3_abort: acks %0d errs %0d want 0/0", nack, nerr); end
        xfer(2, 1'b0, 32'h1C, 4'hF, 32'h0, 3, lat, nack, nerr, rd);
        n_cmp++; if (lat !== 4 || nack !== 1 || rd !== 32'h1122_3344) begin n_bad++; $display("FAIL ws3_rd: lat %0d acks %0d data %h want 4/1/11223344", lat, nack, rd); end
    endtask

    task automatic test_reset_mid();
        int acks;
        @(negedge clk);
        cyc = 1'b1; stbv = 3'b010; we = 1'b1; adr = 32'h14; sel = 4'hF; wdat = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (to1 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags: timeout %b done %b want 0/0", to1, done1); end
        n_cmp++; if (bus1.ack !== 1'b0 || bus1.err !== 1'b0 || bus1.dat_r !== 32'h0) begin n_bad++; $display("FAIL rst_mid_bus: ack %b err %b dat %h want 0/0/0", bus1.ack, bus1.err, bus1.dat_r); end
        cyc = 1'b0; stbv = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus1.ack || bus1.err) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rst_mid_noack: got %0d responses want 0", acks); end
        xfer(1, 1'b0, 32'h14, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'hAAAA_5678) begin n_bad++; $display("FAIL rst_mid_nowrite: got %h want aaaa5678", rd); end
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1, lat, nack, nerr, rd);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rst_mid_preload: got %h want 0badf00d", rd); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_byte_lanes();
        test_error();
        test_abort();
        test_back_to_back();
        test_mailbox();
        test_clear_timeout();
        test_wait0();
        test_wait3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: run did not complete within bound");
        $fatal(1);
    end
endmodule
